ahb_lite_interconnect: RTL
==========================

# ahb_lite_interconnect

Parametrised AHB-Lite single-master interconnect for the schoolMIPS bus, the successor of the fixed four-slave matrix. Address map, slave count and timeout are parameters. It adds a built-in default slave that gives the protocol-correct two-cycle ERROR response, a per-transfer HREADYOUT timeout watchdog, and a sticky error-capture register. It sits between the CPU AHB-Lite master port and the peripheral slaves (RAM, GPIO, ETH, ...).

## Interface
- SLAVE_COUNT, 4, number of slave ports N (1..16)
- ADDR_BASE, {N{32'h0}}, packed N×32 base addresses; slave i uses bits [32i+31:32i]
- ADDR_MASK, {N{32'hFFFF_FFFF}}, packed N×32 compare masks
- TIMEOUT, 255, stall cycles before forced error; 0 disables the watchdog
- HCLK  in  1  bus clock; the block's only clock
- HRESET  in  1  reset; reset is asynchronous and active-high
- HTRANS  in  2  master transfer type
- HADDR  in  32  master address
- HWRITE, HWDATA  in  1/32  master signals, routed directly to all slaves
- HRDATA  out  32  read data to master
- HREADY  out  1  to master; also broadcast to every slave HREADY input
- HRESP  out  1  to master
- S_HSEL  out  N  per-slave address-phase select
- S_HRDATA  in  32N  packed slave read data
- S_HREADYOUT  in  N  slave ready outputs
- S_HRESP  in  N  slave responses
- err_valid  out  1  sticky error flag
- err_code  out  1  0 = decode error, 1 = timeout
- err_addr  out  32  address of the first transfer that failed since the last clear
- err_clr  in  1  single-cycle clear of the capture register

## Operation
- Decode is combinational: match[i] = ((HADDR & MASK_i) == (BASE_i & MASK_i)). The lowest matching index wins, so S_HSEL is always one-hot or zero. S_HSEL is not gated by HTRANS.
- Data-phase select sel_r holds N+1 states: slave i, DEFAULT, or NONE.
  - sel_r is loaded only when HREADY=1.
  - If a slave matches, sel_r = that slave.
  - If nothing matches and HTRANS[1]=1 (NONSEQ/SEQ), sel_r = DEFAULT.
  - If nothing matches and the transfer is IDLE/BUSY, sel_r = NONE.
  - The transfer address is captured into addr_r on the same edge.
- Response mux, by sel_r:
  - Slave i: HRDATA, HREADY and HRESP come from slave i.
  - NONE: HRDATA=0, HREADY=1, HRESP=0.
- Error FSM (default slave plus watchdog) has states OKAY, ERR1, ERR2.
  - OKAY → ERR1 when sel_r=DEFAULT is entered, or when the watchdog expires.
  - ERR1 drives HREADY=0, HRESP=1.
  - ERR1 → ERR2 unconditionally. ERR2 drives HREADY=1, HRESP=1.
  - ERR2 → OKAY. sel_r reloads on that edge.
  - During ERR1 and ERR2, HRDATA=0 and slave responses are ignored.
- Watchdog:
  - The counter increments each cycle that sel_r = slave i, S_HREADYOUT[i]=0 and the FSM is in OKAY.
  - It clears on any cycle with HREADY=1.
  - When count == TIMEOUT-1 and the slave is still stalled, the FSM enters ERR1 on the next edge.
  - The counter width is $clog2(TIMEOUT+1).
- Error capture:
  - On entry to ERR1: if err_valid=0, load err_code and err_addr=addr_r, then set err_valid.
  - If err_valid is already set, the capture holds.
  - err_clr clears err_valid.
  - If err_clr and an ERR1 entry occur in the same cycle, the capture loads and err_valid stays 1.

## Timing
- Reset values:
  - Registers: sel_r=NONE, FSM=OKAY, counter=0, err_valid=0, err_code=0, err_addr=0.
  - Resulting outputs: HREADY=1, HRESP=0, HRDATA=0.
- Zero added latency: the address phase passes straight through, and data-phase responses are combinational from sel_r and the slave inputs.
- Decode error: the data phase takes exactly 2 cycles (ERR1, ERR2). The next address phase is accepted at the end of ERR2.
- Timeout: HRESP=1 is seen TIMEOUT+1 cycles after the data phase starts, with HREADY=1 one cycle later.
- Reset asserted mid-transfer returns all state to reset values immediately. No partial error is captured.
- A decode error back-to-back with a decode error gives ERR1, ERR2, ERR1, ERR2, with no OKAY cycle between.

## Structure
- Shared header ahb_lite.vh holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
  - HRESP OKAY/ERROR
  - FSM state encodings
- Sub-module ahb_lite_default_slave contains the error FSM, the watchdog counter and the error-capture register.
- The top level holds the decoder, the sel_r/addr_r registers and the response mux (generate loop over N).

## Test plan
- Reset, then a NONSEQ read of a RAM-mapped address with the RAM giving 1 wait state → S_HSEL=0001; HRDATA equals the slave data when HREADY=1 in data cycle 2; HRESP=0.
- NONSEQ to unmapped address 0xDEAD_0000 → ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1); err_valid=1, err_code=0, err_addr=0xDEAD_0000.
- IDLE to an unmapped address → zero-wait OKAY; err_valid unchanged.
- TIMEOUT=8, slave holds HREADYOUT=0 → HRESP=1 in cycle 9 of the data phase with HREADY=0; cycle 10 has HREADY=1 and HRESP=1; err_code=1.
- Second error while err_valid=1 → err_addr keeps the first address. Then err_clr pulsed in the same cycle as a new ERR1 entry → err_valid=1 and err_addr holds the new address.
- Overlapping windows (slaves 1 and 2 both match 0x0001_0000) → only S_HSEL[1] is set. Reset asserted during ERR1 → HREADY=1, HRESP=0, err_valid=0 immediately.

Source files
------------

// File: rtl/ahb_lite_interconnect_pkg.sv
// Shared encodings and types for the AHB-Lite interconnect: transfer types,
// response codes, error FSM states and the data-phase response bundle.
package ahb_lite_interconnect_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_OKAY = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  localparam logic ERR_DECODE  = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        resp;
  } ahb_rsp_t;

  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/ahb_lite_interconnect_if.sv
// Master-side AHB-Lite bus. HWRITE/HWDATA are fanned out to the peripherals
// straight off this bus; the interconnect never looks at them.
interface ahb_lite_interconnect_if;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (output HTRANS, HADDR, HWRITE, HWDATA, input HRDATA, HREADY, HRESP);
  modport slave  (input HTRANS, HADDR, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ahb_lite_default_slave.sv
// Default slave: two-cycle ERROR FSM, HREADYOUT stall watchdog and the sticky
// first-error capture register.
module ahb_lite_default_slave
  import ahb_lite_interconnect_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_err,
  input  logic        stall,
  input  logic        hready,
  input  logic [31:0] haddr,
  input  logic [31:0] addr_r,
  input  logic        err_clr,
  output logic [1:0]  state,
  output logic        err_valid,
  output logic        err_code,
  output logic [31:0] err_addr
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;
  logic [1:0]    state_nxt;
  logic          wd_exp;
  logic          enter;

  assign wd_exp = (TIMEOUT != 0) && (state == ST_OKAY) && stall && (cnt == WD_LAST);

  // ERR2 already has HREADY high, so a fresh decode error chains straight into ERR1
  always_comb begin
    case (state)
      ST_OKAY: state_nxt = (dec_err || wd_exp) ? ST_ERR1 : ST_OKAY;
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = dec_err ? ST_ERR1 : ST_OKAY;
    endcase
  end

  assign enter = (state_nxt == ST_ERR1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OKAY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (hready)
        cnt <= '0;
      else if (state == ST_OKAY && stall)
        cnt <= cnt + CW'(1);
    end
  end

  // a decode error captures the address being accepted now, a timeout the stalled one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= ERR_DECODE;
      err_addr  <= '0;
    end else if (enter && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_code  <= wd_exp ? ERR_TIMEOUT : ERR_DECODE;
      err_addr  <= dec_err ? haddr : addr_r;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: masked address decode, data-phase select
// register and response mux, with a built-in default slave for errors.
module ahb_lite_interconnect
  import ahb_lite_interconnect_pkg::*;
#(
  parameter int                          SLAVE_COUNT = 4,
  parameter logic [32*SLAVE_COUNT-1:0]   ADDR_BASE   = {SLAVE_COUNT{32'h0}},
  parameter logic [32*SLAVE_COUNT-1:0]   ADDR_MASK   = {SLAVE_COUNT{32'hFFFF_FFFF}},
  parameter int                          TIMEOUT     = 255
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  ahb_lite_interconnect_if.slave       bus,
  output logic [SLAVE_COUNT-1:0]       S_HSEL,
  input  logic [32*SLAVE_COUNT-1:0]    S_HRDATA,
  input  logic [SLAVE_COUNT-1:0]       S_HREADYOUT,
  input  logic [SLAVE_COUNT-1:0]       S_HRESP,
  output logic                         err_valid,
  output logic                         err_code,
  output logic [31:0]                  err_addr,
  input  logic                         err_clr
);
  localparam int N  = SLAVE_COUNT;
  localparam int SW = $clog2(N + 2);
  // sel_r codes: 0..N-1 slave, N default slave, N+1 nothing selected
  localparam logic [SW-1:0] SEL_DEF  = SW'(N);
  localparam logic [SW-1:0] SEL_NONE = SW'(N + 1);

  logic [N-1:0]  match;
  logic [31:0]   s_rdata [N];
  logic [SW-1:0] sel_nxt, sel_r;
  logic [31:0]   addr_r;
  logic [1:0]    err_state;
  logic          dec_err;
  ahb_rsp_t      slv_rsp, bus_rsp;

  for (genvar i = 0; i < N; i++) begin : g_slv
    assign match[i]   = addr_hit(bus.HADDR, ADDR_BASE[32*i +: 32], ADDR_MASK[32*i +: 32]);
    assign s_rdata[i] = S_HRDATA[32*i +: 32];
  end

  // isolate the lowest set bit: lowest index wins on overlapping windows
  assign S_HSEL = match & (~match + N'(1));

  always_comb begin
    sel_nxt = bus.HTRANS[1] ? SEL_DEF : SEL_NONE;
    for (int i = N - 1; i >= 0; i--)
      if (match[i]) sel_nxt = SW'(i);
  end

  assign dec_err = bus.HREADY && (sel_nxt == SEL_DEF);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_r  <= SEL_NONE;
      addr_r <= '0;
    end else if (bus.HREADY) begin
      sel_r  <= sel_nxt;
      addr_r <= bus.HADDR;
    end
  end

  always_comb begin
    slv_rsp = '{rdata: '0, ready: 1'b1, resp: HRESP_OKAY};
    for (int i = 0; i < N; i++)
      if (sel_r == SW'(i))
        slv_rsp = '{rdata: s_rdata[i], ready: S_HREADYOUT[i], resp: S_HRESP[i]};
    bus_rsp = slv_rsp;
    if (err_state != ST_OKAY)
      bus_rsp = '{rdata: '0, ready: (err_state == ST_ERR2), resp: HRESP_ERROR};
  end

  assign bus.HRDATA = bus_rsp.rdata;
  assign bus.HREADY = bus_rsp.ready;
  assign bus.HRESP  = bus_rsp.resp;

  ahb_lite_default_slave #(.TIMEOUT(TIMEOUT)) u_def (
    .clk       (HCLK),
    .rst       (HRESET),
    .dec_err   (dec_err),
    .stall     (!slv_rsp.ready),
    .hready    (bus.HREADY),
    .haddr     (bus.HADDR),
    .addr_r    (addr_r),
    .err_clr   (err_clr),
    .state     (err_state),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_addr  (err_addr)
  );

endmodule
